// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
//   Shared definitions for the ALU operation sequencer:
//   - opcode encodings understood by the 8-bit combinational ALU
//   - FSM state encoding of the sequencer
//   - alu_ref(): reference ALU behaviour used by the optional self-check
//     (compiled in by the ALU_CHECK_EN macro in alu_op_sequencer)
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam logic [2:0] OP_ADD         = 3'b000;
    localparam logic [2:0] OP_SUB         = 3'b001;
    localparam logic [2:0] OP_AND         = 3'b010;
    localparam logic [2:0] OP_OR          = 3'b011;
    localparam logic [2:0] OP_NOT         = 3'b100;
    localparam logic [2:0] OP_ILLEGAL_MIN = 3'b101;

    // Widest data path the reference function supports; callers mask the
    // result down to their own width, which keeps ADD/SUB/NOT modulo 2^W.
    localparam int ALU_REF_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    function automatic logic [ALU_REF_W-1:0] alu_ref(
        input logic [ALU_REF_W-1:0] a,
        input logic [ALU_REF_W-1:0] b,
        input logic [2:0]           op
    );
        logic [ALU_REF_W-1:0] r;
        case (op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_NOT:  r = ~a;
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// -----------------------------------------------------------------------------
// alu_cmd_fifo
//   Synchronous command FIFO, DEPTH entries (power of two, >= 2).
//   Pointers carry one extra wrap bit so full and empty are distinguishable.
//   Read data is the current head (show-ahead), valid whenever !empty.
// Ports
//   clk, rst          clock, synchronous active-high reset (flushes pointers)
//   push, push_data   write request / data (ignored when full)
//   pop               remove head (ignored when empty)
//   pop_data          head entry
//   full, empty       occupancy status from registered pointers
// -----------------------------------------------------------------------------
module alu_cmd_fifo #(
    parameter int WIDTH = 23,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: entries are only read once the pointers say so.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// alu_op_sequencer
//   Initiator-side driver for the 8-bit combinational ALU. Tagged commands are
//   buffered in alu_cmd_fifo, issued one at a time through registered
//   alu_a/alu_b/alu_sel, and the ALU result is captured one cycle later and
//   returned with tag and flags on a valid/ready response stream.
//   Throughput with rsp_ready=1 is one response every 2 cycles; capacity is
//   DEPTH FIFO entries plus the one command held by the FSM.
// Configuration
//   ALU_CHECK_EN  when defined, an internal reference model checks alu_result
//                 and flags mismatches on rsp_err; otherwise rsp_err is 0.
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   cmd_valid/cmd_ready          command handshake (ready = FIFO not full)
//   cmd_a, cmd_b, cmd_op, cmd_tag  command payload
//   alu_a, alu_b, alu_sel        registered operands/opcode to the ALU
//   alu_result                   combinational result from the ALU
//   rsp_valid/rsp_ready          response handshake
//   rsp_result, rsp_tag          captured result and echoed tag
//   rsp_zero, rsp_illegal, rsp_err  status flags
//   busy                         FSM not idle or FIFO not empty
// -----------------------------------------------------------------------------
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int TAG_W  = 4,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic [2:0]        cmd_op,
    input  logic [TAG_W-1:0]  cmd_tag,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_sel,
    input  logic [DATA_W-1:0] alu_result,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic              rsp_zero,
    output logic              rsp_illegal,
    output logic              rsp_err,
    output logic              busy
);

    localparam int CMD_W = 2*DATA_W + 3 + TAG_W;

    state_t            state;
    state_t            state_n;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_push;
    logic              fifo_pop;
    logic [CMD_W-1:0]  fifo_rdata;
    logic [DATA_W-1:0] head_a;
    logic [DATA_W-1:0] head_b;
    logic [2:0]        head_op;
    logic [TAG_W-1:0]  head_tag;
    logic [TAG_W-1:0]  tag_q;

    // Ready depends only on registered occupancy; a pop this cycle does not
    // open a slot until the next one.
    assign cmd_ready = !fifo_full;
    assign fifo_push = cmd_valid && cmd_ready;
    assign busy      = (state != ST_IDLE) || !fifo_empty;

    assign {head_a, head_b, head_op, head_tag} = fifo_rdata;

    alu_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data ({cmd_a, cmd_b, cmd_op, cmd_tag}),
        .pop       (fifo_pop),
        .pop_data  (fifo_rdata),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n  = state;
        fifo_pop = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_n  = ST_ISSUE;
                end
            end
            ST_ISSUE: state_n = ST_RESP;
            ST_RESP: begin
                if (rsp_ready) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        state_n  = ST_ISSUE;
                    end else begin
                        state_n  = ST_IDLE;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Operand registers load on every pop and otherwise hold, so the ALU
    // sees stable inputs through IDLE and RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a   <= '0;
            alu_b   <= '0;
            alu_sel <= '0;
            tag_q   <= '0;
        end else if (fifo_pop) begin
            alu_a   <= head_a;
            alu_b   <= head_b;
            alu_sel <= head_op;
            tag_q   <= head_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid   <= 1'b0;
            rsp_result  <= '0;
            rsp_tag     <= '0;
            rsp_zero    <= 1'b0;
            rsp_illegal <= 1'b0;
        end else if (state == ST_ISSUE) begin
            rsp_valid   <= 1'b1;
            rsp_result  <= alu_result;
            rsp_tag     <= tag_q;
            rsp_zero    <= (alu_result == '0);
            rsp_illegal <= (alu_sel >= OP_ILLEGAL_MIN);
        end else if (state == ST_RESP && rsp_ready) begin
            // Drop valid on every handshake; if another command was popped
            // it reappears after its ISSUE cycle.
            rsp_valid   <= 1'b0;
        end
    end

`ifdef ALU_CHECK_EN
    localparam logic [ALU_REF_W-1:0] RES_MASK =
        ALU_REF_W'((64'd1 << DATA_W) - 64'd1);

    logic                 rsp_err_q;
    logic [ALU_REF_W-1:0] ref_res;

    assign ref_res = alu_ref(ALU_REF_W'(alu_a), ALU_REF_W'(alu_b), alu_sel) & RES_MASK;
    assign rsp_err = rsp_err_q;

    always_ff @(posedge clk) begin
        if (rst)                    rsp_err_q <= 1'b0;
        else if (state == ST_ISSUE) rsp_err_q <= (ALU_REF_W'(alu_result) != ref_res);
    end
`else
    assign rsp_err = 1'b0;
`endif

endmodule
